// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared constants for the pipeline hazard controller:
//               MDU FSM state encodings, the "operand unused" Tuse marker
//               and the default MDU latencies.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    // MDU busy FSM state encodings
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    // Tuse value marking an operand the D-stage instruction does not read
    localparam logic [1:0] c_TUSE_UNUSED = 2'd3;

    // Default MDU busy cycles
    localparam int c_MULT_CYC_DEF = 5;
    localparam int c_DIV_CYC_DEF  = 10;

    // Counter width able to hold the larger of the two latencies
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_mdu_busy_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mdu_busy_fsm
// Description : Two-state (IDLE/BUSY) tracker of the multiply/divide unit.
//               A start in IDLE loads the latency counter; BUSY counts down
//               and returns to IDLE on the edge where the counter reads 1.
//               Starts seen while BUSY are ignored.
// Ports       : clk    - clock, rising edge
//               reset  - synchronous, active-low reset
//               start  - mult/div issued from E stage this cycle
//               is_div - qualifies start: 1 = div, 0 = mult
//               busy   - MDU operation in progress
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_busy_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = c_MULT_CYC_DEF,
    parameter int DIV_CYC  = c_DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int c_CNT_W = cnt_width(MULT_CYC, DIV_CYC);
    localparam logic [c_CNT_W-1:0] c_MULT_LD = c_CNT_W'(MULT_CYC);
    localparam logic [c_CNT_W-1:0] c_DIV_LD  = c_CNT_W'(DIV_CYC);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_BUSY;
                    w_cnt_nxt   = is_div ? c_DIV_LD : c_MULT_LD;
                end
            end
            c_ST_BUSY: begin
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt == c_ONE) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign busy = (r_state == c_ST_BUSY);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush controller for a 5-stage pipeline. Compares the
//               D-stage source registers against the E/M destinations using
//               Tuse/Tnew timing, adds an MDU-busy stall, and drives the
//               F/D write enables and the E bubble. Optional stall-cycle
//               counter is built only when STALL_CNT_EN is defined;
//               otherwise stall_cnt is tied to zero.
// Ports       : clk, reset (sync active-low)
//               D_rs/D_rt, D_Tuse_rs/D_Tuse_rt, D_is_MDU - D-stage operands
//               E_A3/E_Tnew, M_A3/M_Tnew                 - producers in E/M
//               E_start/E_is_div                          - MDU issue
//               F_WE, D_WE, E_Flush                       - pipeline control
//               MDU_busy, stall_cnt                        - status
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = c_MULT_CYC_DEF,
    parameter int DIV_CYC  = c_DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_MDU,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_Tnew,
    input  logic        E_start,
    input  logic        E_is_div,
    output logic        F_WE,
    output logic        D_WE,
    output logic        E_Flush,
    output logic        MDU_busy,
    output logic [31:0] stall_cnt
);

    logic w_stall_rs;
    logic w_stall_rt;
    logic w_stall_mdu;
    logic w_stall;

    // A source must wait while some producer's result arrives later than
    // the source is needed. $zero is never a real dependency. An unused
    // operand (Tuse = 3) can never be exceeded by a legal Tnew, but it is
    // excluded explicitly so out-of-range Tnew values cannot stall either.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        logic w_e_hit;
        logic w_m_hit;
        w_e_hit = (src == e_a3) && (e_tnew > tuse);
        w_m_hit = (src == m_a3) && (m_tnew > tuse);
        return (src != 5'd0) && (tuse != c_TUSE_UNUSED) && (w_e_hit || w_m_hit);
    endfunction

    assign w_stall_rs = src_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
    assign w_stall_rt = src_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);

    // E_start is included so an MDU instruction right behind a just-issued
    // mult/div stalls in the issue cycle, before MDU_busy rises.
    assign w_stall_mdu = D_is_MDU && (MDU_busy || E_start);

    assign w_stall = w_stall_rs | w_stall_rt | w_stall_mdu;

    assign F_WE    = ~w_stall;
    assign D_WE    = ~w_stall;
    assign E_Flush = w_stall;

    mdu_busy_fsm #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_mdu_busy_fsm (
        .clk    (clk),
        .reset  (reset),
        .start  (E_start),
        .is_div (E_is_div),
        .busy   (MDU_busy)
    );

`ifdef STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
